// File: rtl/mem_boot_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_boot_loader_if
// Description : Bundle of the boot loader's host byte stream, memory write
//               port and CPU control/status signals.
//   start      host -> loader  one-cycle load request
//   byte_in    host -> loader  stream data byte
//   byte_valid host -> loader  byte_in is valid
//   byte_ready loader -> host  loader accepts a byte this cycle
//   mem_we     loader -> mem   one-cycle write strobe per word
//   mem_addr   loader -> mem   word address of the write
//   mem_wdata  loader -> mem   word written (big-endian packed)
//   cpu_reset  loader -> cpu   active-high CPU reset
//   busy/done/err              loader status
// Modports    : master (host side / bench), slave (loader)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_boot_loader
// Description : Boot-time image loader. Packs a valid/ready byte stream
//               big-endian into 32-bit words, writes them to the shared
//               instruction/data memory from word address 0 and holds the
//               CPU in reset until the image is in memory, then releases it.
// Ports       : clk_i   - system clock, rising edge
//               reset_i - synchronous active-high reset
//               bus_if  - mem_boot_loader_if.slave (stream, memory, status)
// Parameters  : ADDR_W      - word address width
//               WORD_COUNT  - 32-bit words per image (1..2**ADDR_W)
//               HOLD_CYCLES - cpu_reset cycles after the final write (>=1)
// Options     : BOOT_CHECKSUM_EN - when defined, a trailer byte following
//               the image must equal the XOR of all image bytes, otherwise
//               the loader parks in ERROR with err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_boot_loader #(
  parameter int ADDR_W      = 8,
  parameter int WORD_COUNT  = 64,
  parameter int HOLD_CYCLES = 4
) (
  input  wire logic        clk_i,
  input  wire logic        reset_i,
  mem_boot_loader_if.slave bus_if
);

  localparam int              HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_HOLD  = 3'd4,
    S_RUN   = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  // Only the first three bytes of a word need storing; the fourth comes
  // straight from the bus into mem_wdata.
  logic [23:0]         word_q, word_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                byte_ready_q, byte_ready_d;
  logic                mem_we_q, mem_we_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0]          chk_q, chk_d;
  logic                err_q, err_d;
`endif

  // Ready is registered, so a transfer is decided entirely by the current
  // cycle's valid and the ready the host already sees.
  assign accept = bus_if.byte_valid && byte_ready_q;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    hold_cnt_d  = hold_cnt_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef BOOT_CHECKSUM_EN
    chk_d       = chk_q;
`endif

    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (bus_if.start) begin
          state_d    = S_LOAD;
          byte_cnt_d = 2'd0;
          addr_d     = '0;
          hold_cnt_d = '0;
`ifdef BOOT_CHECKSUM_EN
          chk_d      = 8'h00;
`endif
        end
      end

      S_LOAD: begin
        if (accept) begin
          word_d     = {word_q[15:0], bus_if.byte_in};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          chk_d      = chk_q ^ bus_if.byte_in;
`endif
          if (byte_cnt_q == 2'd3) begin
            state_d     = S_WRITE;
            mem_addr_d  = addr_q;
            mem_wdata_d = {word_q, bus_if.byte_in};
          end
        end
      end

      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          hold_cnt_d = '0;
`ifdef BOOT_CHECKSUM_EN
          state_d    = S_CHECK;
`else
          state_d    = S_HOLD;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LOAD;
        end
      end

`ifdef BOOT_CHECKSUM_EN
      S_CHECK: begin
        // Trailer byte is compared, never folded into the checksum.
        if (accept) begin
          hold_cnt_d = '0;
          state_d    = (bus_if.byte_in == chk_q) ? S_HOLD : S_ERROR;
        end
      end
`endif

      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the
    // state they describe.
    byte_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
    mem_we_d     = (state_d == S_WRITE);
    cpu_reset_d  = (state_d != S_RUN);
    busy_d       = (state_d == S_LOAD) || (state_d == S_WRITE) ||
                   (state_d == S_CHECK) || (state_d == S_HOLD);
    done_d       = (state_d == S_RUN);
`ifdef BOOT_CHECKSUM_EN
    err_d        = (state_d == S_ERROR);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      addr_q       <= '0;
      hold_cnt_q   <= '0;
      word_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      chk_q        <= 8'h00;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      hold_cnt_q   <= hold_cnt_d;
      word_q       <= word_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef BOOT_CHECKSUM_EN
      chk_q        <= chk_d;
      err_q        <= err_d;
`endif
    end
  end

  assign bus_if.byte_ready = byte_ready_q;
  assign bus_if.mem_we     = mem_we_q;
  assign bus_if.mem_addr   = mem_addr_q;
  assign bus_if.mem_wdata  = mem_wdata_q;
  assign bus_if.cpu_reset  = cpu_reset_q;
  assign bus_if.busy       = busy_q;
  assign bus_if.done       = done_q;
`ifdef BOOT_CHECKSUM_EN
  assign bus_if.err        = err_q;
`else
  assign bus_if.err        = 1'b0;
`endif

endmodule
`default_nettype wire
